// File: rtl/serialrx.sv
// Serial-in parallel-out receiver: MSB-first words are assembled in a shift
// register and queued in a first-word-fall-through FIFO with sticky overrun.
module serialrx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_in,
   input  logic                     i_rxen,
   input  logic                     i_ready,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_valid,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_busy,
   output logic                     o_overrun
);

   localparam int CW    = $clog2(WIDTH);
   localparam int AW    = $clog2(DEPTH);
   localparam int NW    = AW + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

   // Only WIDTH-1 bits are stored: the final bit goes straight into the FIFO.
   logic [WIDTH-2:0] shreg_q,  shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [NW-1:0]    count_q,  count_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [WIDTH-1:0] word_s;
   logic             push_s;
   logic             pop_s;
   logic             full_s;
   logic             wr_s;

   // Shift register and bit counter next state.
   always_comb begin
      word_s   = {shreg_q, i_in};
      push_s   = i_rxen && (bitcnt_q == LAST_BIT);
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      if (i_rxen) begin
         shreg_d = word_s[WIDTH-2:0];
         if (push_s) begin
            bitcnt_d = {CW{1'b0}};
         end else begin
            bitcnt_d = bitcnt_q + CW'(1);
         end
      end else begin
         shreg_d  = shreg_q;
         bitcnt_d = bitcnt_q;
      end
   end

   // FIFO control; a full FIFO still accepts a push when the head leaves on the same edge.
   always_comb begin
      full_s    = (count_q == FULL_CNT);
      pop_s     = (count_q != {NW{1'b0}}) && i_ready;
      wr_s      = push_s && (!full_s || pop_s);
      overrun_d = overrun_q | (push_s && full_s && !pop_s);
      if (wr_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, pop_s})
         2'b10:   count_d = count_q + NW'(1);
         2'b01:   count_d = count_q - NW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         shreg_q   <= {(WIDTH-1){1'b0}};
         bitcnt_q  <= {CW{1'b0}};
         wr_ptr_q  <= {AW{1'b0}};
         rd_ptr_q  <= {AW{1'b0}};
         count_q   <= {NW{1'b0}};
         overrun_q <= 1'b0;
      end else begin
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   // FIFO storage, cleared on reset so the idle head reads as zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (wr_s) begin
         mem_q[wr_ptr_q] <= word_s;
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

   assign o_data    = mem_q[rd_ptr_q];
   assign o_valid   = (count_q != {NW{1'b0}});
   assign o_count   = count_q;
   assign o_busy    = (bitcnt_q != {CW{1'b0}});
   assign o_overrun = overrun_q;

endmodule

// File: tb/tb_serialrx.sv
// Directed bench for serialrx: table of single words plus hand sequences
// for reset, transmitter alignment, overrun, full push/pop and streaming.
module tb_serialrx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drv_in = 1'b0;
   logic       drv_rxen = 1'b0;
   logic       rdy = 1'b0;
   logic       use_tx = 1'b0;
   logic       tx_load = 1'b0;
   logic [7:0] tx_word = 8'h00;
   logic       txen = 1'b0;
   logic [7:0] tx_sh = 8'h00;
   logic       tx_q = 1'b0;
   logic       txen_d = 1'b0;

   logic       ser_in;
   logic       rxen;
   logic [7:0] o_data;
   logic       o_valid;
   logic [2:0] o_count;
   logic       o_busy;
   logic       o_overrun;

   int n_cmp = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] word;
      int         gap_after;
      int         gap_len;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   always #5 clk = ~clk;

   // Behavioural model of the upstream registered PISO transmitter.
   always @(posedge clk) begin
      txen_d <= txen;
      if (tx_load) begin
         tx_sh <= tx_word;
      end else if (txen) begin
         tx_q  <= tx_sh[7];
         tx_sh <= {tx_sh[6:0], 1'b0};
      end
   end

   assign ser_in = use_tx ? tx_q   : drv_in;
   assign rxen   = use_tx ? txen_d : drv_rxen;

   serialrx #(.WIDTH(8), .DEPTH(4)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_in      (ser_in),
      .i_rxen    (rxen),
      .i_ready   (rdy),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_count   (o_count),
      .o_busy    (o_busy),
      .o_overrun (o_overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; drv_rxen = 1'b0; rdy = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_bit(input logic b, input logic r);
      @(negedge clk);
      drv_in = b; drv_rxen = 1'b1; rdy = r;
   endtask

   task automatic send_word(input logic [7:0] w, input int gap_after, input int gap_len,
                            input logic ready_last);
      for (int b = 7; b >= 0; b--) begin
         send_bit(w[b], (b == 0) ? ready_last : 1'b0);
         if ((7 - b + 1) == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               drv_rxen = 1'b0; drv_in = 1'b0;
               check("busy_in_gap", {31'd0, o_busy}, 32'd1);
            end
         end
      end
      @(negedge clk);
      drv_rxen = 1'b0; rdy = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_q [$];
      logic [7:0] w;
      int         got;

      vecs[0] = '{8'h81, 3, 3, 8'h81};
      vecs[1] = '{8'h00, 0, 0, 8'h00};
      vecs[2] = '{8'hFF, 0, 0, 8'hFF};
      vecs[3] = '{8'h5A, 5, 1, 8'h5A};
      vecs[4] = '{8'h96, 7, 2, 8'h96};
      vecs[5] = '{8'h01, 1, 4, 8'h01};

      // Power-on reset state.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_busy",    {31'd0, o_busy},    32'd0);
      check("rst_count",   {29'd0, o_count},   32'd0);
      check("rst_valid",   {31'd0, o_valid},   32'd0);
      check("rst_data",    {24'd0, o_data},    32'd0);
      check("rst_overrun", {31'd0, o_overrun}, 32'd0);

      // Reset mid-word discards the partial bits.
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      @(negedge clk);
      drv_rxen = 1'b0;
      check("mid_busy", {31'd0, o_busy}, 32'd1);
      do_reset();
      check("midrst_busy",  {31'd0, o_busy},  32'd0);
      check("midrst_count", {29'd0, o_count}, 32'd0);
      check("midrst_valid", {31'd0, o_valid}, 32'd0);
      check("midrst_data",  {24'd0, o_data},  32'd0);
      send_word(8'hA5, 0, 0, 1'b0);
      check("a5_valid", {31'd0, o_valid}, 32'd1);
      check("a5_data",  {24'd0, o_data},  32'hA5);
      check("a5_count", {29'd0, o_count}, 32'd1);
      pop_one();
      check("a5_popped", {31'd0, o_valid}, 32'd0);

      // Transmitter attached, rxen = txen delayed by one cycle.
      use_tx = 1'b1;
      @(negedge clk);
      tx_load = 1'b1; tx_word = 8'h3C;
      @(negedge clk);
      tx_load = 1'b0; txen = 1'b1;
      repeat (7) @(negedge clk);
      @(negedge clk);
      txen = 1'b0;
      check("tx_not_yet_valid", {31'd0, o_valid}, 32'd0);
      check("tx_busy_before",   {31'd0, o_busy},  32'd1);
      @(negedge clk);
      check("tx_valid", {31'd0, o_valid}, 32'd1);
      check("tx_data",  {24'd0, o_data},  32'h3C);
      check("tx_busy_after", {31'd0, o_busy}, 32'd0);
      @(negedge clk);
      use_tx = 1'b0;
      pop_one();
      check("tx_popped", {31'd0, o_valid}, 32'd0);

      // Table of single words, some with enable gaps.
      foreach (vecs[i]) begin
         send_word(vecs[i].word, vecs[i].gap_after, vecs[i].gap_len, 1'b0);
         check("vec_valid", {31'd0, o_valid}, 32'd1);
         check("vec_data",  {24'd0, o_data},  {24'd0, vecs[i].exp_data});
         check("vec_busy",  {31'd0, o_busy},  32'd0);
         pop_one();
         check("vec_empty", {29'd0, o_count}, 32'd0);
      end

      // Fill and overrun, then drain in order.
      for (int i = 1; i <= 5; i++) send_word(8'(i), 0, 0, 1'b0);
      check("fill_count",   {29'd0, o_count},   32'd4);
      check("fill_overrun", {31'd0, o_overrun}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         check("drain_data", {24'd0, o_data}, i);
         pop_one();
      end
      check("drain_valid",   {31'd0, o_valid},   32'd0);
      check("drain_overrun", {31'd0, o_overrun}, 32'd1);
      do_reset();
      check("ovr_cleared", {31'd0, o_overrun}, 32'd0);

      // Push and pop on the same edge while full.
      send_word(8'h10, 0, 0, 1'b0);
      send_word(8'h20, 0, 0, 1'b0);
      send_word(8'h30, 0, 0, 1'b0);
      send_word(8'h40, 0, 0, 1'b0);
      check("pp_full", {29'd0, o_count}, 32'd4);
      send_word(8'h55, 0, 0, 1'b1);
      check("pp_count",   {29'd0, o_count},   32'd4);
      check("pp_overrun", {31'd0, o_overrun}, 32'd0);
      check("pp_d0", {24'd0, o_data}, 32'h20); pop_one();
      check("pp_d1", {24'd0, o_data}, 32'h30); pop_one();
      check("pp_d2", {24'd0, o_data}, 32'h40); pop_one();
      check("pp_d3", {24'd0, o_data}, 32'h55); pop_one();
      check("pp_empty", {31'd0, o_valid}, 32'd0);

      // Streaming: ten back-to-back words with the consumer always ready.
      got = 0;
      for (int i = 0; i < 10; i++) begin
         w = 8'((i * 37) + 11);
         exp_q.push_back(w);
         for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            if (o_valid) begin
               check("stream_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
               got++;
            end
            if (o_count > 3'd1) check("stream_count_max", {29'd0, o_count}, 32'd1);
            drv_in = w[b]; drv_rxen = 1'b1; rdy = 1'b1;
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drv_rxen = 1'b0;
         if (o_valid) begin
            if (exp_q.size() == 0) begin
               check("stream_extra_word", {24'd0, o_data}, 32'hFFFF_FFFF);
            end else begin
               check("stream_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
            got++;
         end
      end
      rdy = 1'b0;
      check("stream_words",   got, 32'd10);
      check("stream_overrun", {31'd0, o_overrun}, 32'd0);
      check("stream_empty",   {31'd0, o_valid},   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serialrx.md
# serialrx

Synchronous serial-in parallel-out (SIPO) receiver with a small output FIFO. It is the downstream stage of the team's PISO serial transmitter. It samples the MSB-first bit stream that the transmitter produces, reassembles WIDTH-bit words, and buffers them behind a first-word-fall-through valid/ready interface for the parallel consumer. Overflow is flagged and sticky.

## Interface
- WIDTH, 8: bits per word; must be ≥ 2.
- DEPTH, 4: FIFO entries; must be a power of 2, ≥ 2.

- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_in  in  1  serial data; MSB of each word arrives first.
- i_rxen  in  1  sample enable; i_in is shifted in on every edge where i_rxen=1.
- i_ready  in  1  consumer accepts the head word.
- o_data  out  WIDTH  head-of-FIFO word; valid only while o_valid=1.
- o_valid  out  1  FIFO not empty.
- o_count  out  $clog2(DEPTH)+1  number of words held in the FIFO.
- o_busy  out  1  a partial word is in the shift register (bit counter ≠ 0).
- o_overrun  out  1  sticky; set when a completed word is dropped because the FIFO is full.

## Operation
- Reset (i_rst=1 at an edge) overrides everything:
  - shift register, bit counter, FIFO pointers, o_count, o_overrun and o_busy clear to 0.
  - o_valid=0 and o_data=0. FIFO storage is cleared, or o_data is forced to 0 while empty.
  - A partial word in progress at reset is discarded.
- Shift: on an edge with i_rxen=1:
  - shreg ← {shreg[WIDTH-2:0], i_in};
  - bitcnt ← bitcnt+1, wrapping WIDTH-1 → 0.
- Completion: on an edge with i_rxen=1 and bitcnt=WIDTH-1, the word {shreg[WIDTH-2:0], i_in} is pushed into the FIFO on that same edge. It does not pass through the shift register first.
- i_rxen=0 mid-word: shreg and bitcnt hold; reception resumes on the next enabled edge. No timeout, no abort.
- i_in is not sampled when i_rxen=0. The transmitter drives Z while idle, and that is harmless.
- Alignment with the transmitter: its output is registered, so i_rxen must equal the transmitter's i_txen delayed by one cycle. Upstream logic is responsible for this.
- FIFO is first-word-fall-through:
  - o_valid = (o_count≠0); o_data = mem[rd_ptr].
  - Pop on an edge where o_valid & i_ready.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Push with FIFO full and no pop on the same edge: the word is dropped, o_overrun←1, and FIFO contents are unchanged.
- Push and pop on the same edge:
  - FIFO full: both succeed, o_count is unchanged, and o_overrun is not set.
  - FIFO empty: pop is impossible (o_valid=0); the push succeeds and o_count becomes 1.
- i_ready while o_valid=0 is ignored.
- o_overrun clears only on reset.

## Timing
- Latency: last bit sampled at edge N, so o_valid=1 and o_data equal the word from edge N onward (visible in cycle N+1).
- Back-to-back words with i_rxen held high give one completed word every WIDTH cycles, with no idle bit between words.
- Pop at edge P: the next word, or o_valid=0, appears after edge P.
- o_count, o_valid and o_overrun are registered or derived from registers only, with no combinational path from i_ready or i_rxen.
- o_busy=1 from the edge that shifts the first bit until the completion edge.

## Test plan
- Reset mid-word:
  - Stimulus: shift 5 bits, then assert i_rst for 1 cycle.
  - Required: o_busy=0, o_count=0, o_valid=0, o_data=0.
  - Then send 0xA5: o_data=0xA5, proving no stale bits remain.
- Single word, with transmitter attached:
  - Stimulus: latch 0x3C into the transmitter, hold its i_txen for 8 cycles, drive i_rxen = i_txen delayed by 1.
  - Required: o_valid rises exactly after the 8th sampling edge, with o_data=0x3C; i_ready=1 for one cycle gives o_valid=0.
- Gapped enable:
  - Stimulus: send 0x81 with i_rxen deasserted for 3 cycles after bit 3.
  - Required: o_busy stays 1 during the gap; the result is 0x81.
- Fill and overrun:
  - Stimulus: i_ready=0; send 0x01, 0x02, 0x03, 0x04, then 0x05.
  - Required: o_count=4 and o_overrun=1.
  - Draining yields 0x01–0x04 in order; o_overrun remains 1.
- Simultaneous push/pop when full:
  - Stimulus: FIFO holds 4 words; i_ready=1 on the completion edge of 0x55.
  - Required: o_count stays 4, o_overrun=0; drain order ends with 0x55.
- Streaming:
  - Stimulus: i_rxen held high for 10 consecutive words; i_ready=1 throughout.
  - Required: every word is received intact, o_count never exceeds 1, o_overrun=0.
